bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 26 ++
 rtl/bus_arbiter.sv | 137 +++++++++++++
 tb/tb_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbiter signal bundle for two masters sharing one serial bus.
// The "master" modport is the arbiter's view: it samples requests and
// slave events, and drives grants, split flags and the mux select.
// The "slave" modport is the opposite view, used by the bus agents.
interface bus_arbiter_if;
   logic mbreq1;
   logic mbreq2;
   logic mbgrant1;
   logic mbgrant2;
   logic msplit1;
   logic msplit2;
   logic ssplit;
   logic sready;
   logic msel;
   logic bus_busy;

   modport master (
      input  mbreq1, mbreq2, ssplit, sready,
      output mbgrant1, mbgrant2, msplit1, msplit2, msel, bus_busy
   );

   modport slave (
      output mbreq1, mbreq2, ssplit, sready,
      input  mbgrant1, mbgrant2, msplit1, msplit2, msel, bus_busy
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with single outstanding split support.
// M1 has fixed priority over M2; a split master is locked out until its
// slave signals ready, after which it is resumed ahead of everyone else.
// Every output is a register; the arbiter always spends at least one
// IDLE cycle between two grants.
module bus_arbiter (
   input  logic          clk,
   input  logic          rstn,
   bus_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN1 = 2'd1,
      OWN2 = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [1:0] grant_reg, grant_next;     // bit 0 = M1, bit 1 = M2
   logic [1:0] msplit_reg, msplit_next;   // bit 0 = M1, bit 1 = M2
   logic       msel_reg, msel_next;
   logic       busy_reg, busy_next;
   logic       split_pend_reg, split_pend_next;
   logic       split_id_reg, split_id_next;
   logic       ready_seen_reg, ready_seen_next;

   logic [1:0] req;
   logic [1:0] eligible;

   assign req = {bus.mbreq2, bus.mbreq1};

   // A requester is eligible unless it is the master parked on a split.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_elig
         localparam logic MASTER_ID = 1'(gi);
         assign eligible[gi] = req[gi] && !(split_pend_reg && (split_id_reg == MASTER_ID));
      end
   endgenerate

   // State and all registered outputs; reset discards ownership and any split.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg      <= IDLE;
         grant_reg      <= 2'b00;
         msplit_reg     <= 2'b00;
         msel_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         split_pend_reg <= 1'b0;
         split_id_reg   <= 1'b0;
         ready_seen_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         msplit_reg     <= msplit_next;
         msel_reg       <= msel_next;
         busy_reg       <= busy_next;
         split_pend_reg <= split_pend_next;
         split_id_reg   <= split_id_next;
         ready_seen_reg <= ready_seen_next;
      end
   end

   // Next-state and next-output decode: resume > M1 > M2 in IDLE; split or release in OWNx.
   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      msplit_next     = msplit_reg;
      msel_next       = msel_reg;
      split_pend_next = split_pend_reg;
      split_id_next   = split_id_reg;
      // sready only matters while a split is outstanding; it is remembered
      // so a resume can wait for the current owner to finish.
      ready_seen_next = ready_seen_reg | (split_pend_reg & bus.sready);

      case (state_reg)
         IDLE: begin
            grant_next = 2'b00;
            if (split_pend_reg && ready_seen_reg) begin
               state_next                = split_id_reg ? OWN2 : OWN1;
               grant_next[split_id_reg]  = 1'b1;
               msplit_next[split_id_reg] = 1'b0;
               msel_next                 = split_id_reg;
               split_pend_next           = 1'b0;
               ready_seen_next           = 1'b0;
            end else if (eligible[0]) begin
               state_next = OWN1;
               grant_next = 2'b01;
               msel_next  = 1'b0;
            end else if (eligible[1]) begin
               state_next = OWN2;
               grant_next = 2'b10;
               msel_next  = 1'b1;
            end
         end
         OWN1: begin
            // A split request beats a simultaneous release.
            if (bus.ssplit && !split_pend_reg) begin
               split_pend_next = 1'b1;
               split_id_next   = 1'b0;
               msplit_next[0]  = 1'b1;
               grant_next      = 2'b00;
               state_next      = IDLE;
            end else if (!req[0]) begin
               grant_next = 2'b00;
               state_next = IDLE;
            end
         end
         OWN2: begin
            if (bus.ssplit && !split_pend_reg) begin
               split_pend_next = 1'b1;
               split_id_next   = 1'b1;
               msplit_next[1]  = 1'b1;
               grant_next      = 2'b00;
               state_next      = IDLE;
            end else if (!req[1]) begin
               grant_next = 2'b00;
               state_next = IDLE;
            end
         end
         default: begin
            grant_next = 2'b00;
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   assign bus.mbgrant1 = grant_reg[0];
   assign bus.mbgrant2 = grant_reg[1];
   assign bus.msplit1  = msplit_reg[0];
   assign bus.msplit2  = msplit_reg[1];
   assign bus.msel     = msel_reg;
   assign bus.bus_busy = busy_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of ownership and splits.
module tb_bus_arbiter;

   logic clk;
   logic rstn;
   int   n_asserts;
   int   n_fails;
   int   cyc;

   bus_arbiter_if bus ();

   bus_arbiter dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the bus, who is split, whether the split slave is ready.
   int owner;          // -1 = nobody, 0 = M1, 1 = M2
   int split_who;      // -1 = no split outstanding, else the split master
   bit resume_ready;
   bit last_sel;

   function automatic void model_step();
      int nxt;
      bit pend_before;
      bit ready_after;
      if (!rstn) begin
         owner        = -1;
         split_who    = -1;
         resume_ready = 1'b0;
         last_sel     = 1'b0;
         return;
      end
      pend_before = (split_who >= 0);
      ready_after = resume_ready || (pend_before && bus.sready);
      nxt         = owner;
      if (owner < 0) begin
         if (pend_before && resume_ready) begin
            nxt         = split_who;
            split_who   = -1;
            ready_after = 1'b0;
         end else if (bus.mbreq1 && split_who != 0) begin
            nxt = 0;
         end else if (bus.mbreq2 && split_who != 1) begin
            nxt = 1;
         end
      end else begin
         if (bus.ssplit && !pend_before) begin
            split_who = owner;
            nxt       = -1;
         end else if (!((owner == 0) ? bus.mbreq1 : bus.mbreq2)) begin
            nxt = -1;
         end
      end
      owner        = nxt;
      resume_ready = ready_after;
      if (owner >= 0) last_sel = (owner == 1);
   endfunction

   function automatic logic [5:0] model_out();
      return {owner == 0, owner == 1, split_who == 0, split_who == 1, last_sel, owner >= 0};
   endfunction

   function automatic logic [5:0] dut_out();
      return {bus.mbgrant1, bus.mbgrant2, bus.msplit1, bus.msplit2, bus.msel, bus.bus_busy};
   endfunction

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock: advance the model on the inputs the DUT will sample, then compare after the edge.
   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d %s req=%b%b ss=%b sr=%b rstn=%b out(g1 g2 s1 s2 sel busy)=%b",
               cyc, tag, bus.mbreq1, bus.mbreq2, bus.ssplit, bus.sready, rstn, dut_out());
      check(tag, dut_out(), model_out());
   endtask

   task automatic do_reset();
      rstn       = 1'b0;
      bus.mbreq1 = 1'b0;
      bus.mbreq2 = 1'b0;
      bus.ssplit = 1'b0;
      bus.sready = 1'b0;
      tick("reset");
      tick("reset");
      rstn = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_asserts = 0;
      n_fails   = 0;
      cyc       = 0;

      // Reset state
      do_reset();
      check("reset_state", dut_out(), 6'b000000);

      // Single request: grant after one edge, release after one edge
      bus.mbreq1 = 1'b1;
      tick("single_req");
      check("single_grant", dut_out(), 6'b100001);
      for (int i = 0; i < 9; i++) tick("single_hold");
      check("single_still", dut_out(), 6'b100001);
      bus.mbreq1 = 1'b0;
      tick("single_rel");
      check("single_release", dut_out(), 6'b000000);

      // Contention: M1 wins, M2 follows after exactly one IDLE cycle
      do_reset();
      bus.mbreq1 = 1'b1;
      bus.mbreq2 = 1'b1;
      tick("cont_req");
      check("cont_m1_first", dut_out(), 6'b100001);
      tick("cont_hold");
      bus.mbreq1 = 1'b0;
      tick("cont_rel1");
      check("cont_dead_cycle", dut_out(), 6'b000000);
      tick("cont_m2");
      check("cont_m2_grant", dut_out(), 6'b010011);
      bus.mbreq2 = 1'b0;
      tick("cont_rel2");
      check("cont_idle_msel_hold", dut_out(), 6'b000010);

      // Split flow: M1 split, M2 served, sready during M2, M1 resumed
      do_reset();
      bus.mbreq1 = 1'b1;
      tick("split_own1");
      bus.mbreq2 = 1'b1;
      bus.ssplit = 1'b1;
      tick("split_pulse");
      bus.ssplit = 1'b0;
      check("split_m1_parked", dut_out(), 6'b001000);
      tick("split_m2_grant");
      check("split_m2_owns", dut_out(), 6'b011011);
      bus.sready = 1'b1;
      tick("split_ready_busy");
      bus.sready = 1'b0;
      check("split_ready_no_change", dut_out(), 6'b011011);
      bus.mbreq2 = 1'b0;
      tick("split_m2_rel");
      check("split_idle", dut_out(), 6'b001010);
      tick("split_resume");
      check("split_resume_m1", dut_out(), 6'b100001);
      bus.mbreq1 = 1'b0;
      tick("split_m1_rel");

      // Split precedence: a parked M1 is not re-granted until sready
      do_reset();
      bus.mbreq1 = 1'b1;
      tick("prec_own1");
      bus.ssplit = 1'b1;
      tick("prec_split");
      bus.ssplit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick("prec_wait");
         check("prec_locked_out", dut_out(), 6'b001000);
      end
      bus.sready = 1'b1;
      tick("prec_ready");
      bus.sready = 1'b0;
      tick("prec_resume");
      check("prec_resume_m1", dut_out(), 6'b100001);
      bus.mbreq1 = 1'b0;
      tick("prec_rel");

      // sready with nothing split changes nothing
      bus.sready = 1'b1;
      tick("stray_ready");
      bus.sready = 1'b0;
      check("stray_ready_ignored", dut_out(), 6'b000000);
      tick("stray_after");
      check("stray_ready_no_grant", dut_out(), 6'b000000);

      // Second split while one is outstanding is ignored
      do_reset();
      bus.mbreq1 = 1'b1;
      bus.mbreq2 = 1'b1;
      tick("dbl_own1");
      bus.ssplit = 1'b1;
      tick("dbl_split1");
      bus.ssplit = 1'b0;
      tick("dbl_own2");
      bus.ssplit = 1'b1;
      tick("dbl_split2");
      bus.ssplit = 1'b0;
      check("dbl_split_ignored", dut_out(), 6'b011011);

      // Reset mid-split discards everything; a later sready grants nothing
      bus.mbreq2 = 1'b0;
      tick("rst_m2_rel");
      check("rst_pre_split_flag", dut_out(), 6'b001010);
      rstn = 1'b0;
      tick("rst_mid_split");
      check("rst_all_zero", dut_out(), 6'b000000);
      rstn       = 1'b1;
      bus.mbreq1 = 1'b0;
      bus.sready = 1'b1;
      tick("rst_late_ready");
      bus.sready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick("rst_no_grant");
         check("rst_no_resume", dut_out(), 6'b000000);
      end

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         if (bus.mbreq1) bus.mbreq1 = ($urandom_range(0, 7) != 0);
         else            bus.mbreq1 = ($urandom_range(0, 3) == 0);
         if (bus.mbreq2) bus.mbreq2 = ($urandom_range(0, 7) != 0);
         else            bus.mbreq2 = ($urandom_range(0, 3) == 0);
         bus.ssplit = ($urandom_range(0, 9) == 0);
         bus.sready = ($urandom_range(0, 9) == 0);
         rstn       = ($urandom_range(0, 199) != 0);
         tick("rand");
         check("rand_no_overlap", {4'b0000, bus.mbgrant1 & bus.mbgrant2, 1'b0}, 6'b000000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
